gray_decoder: RTL and testbench

GRAY_DECODER -- requirements
Module: gray_decoder

---
 rtl/gray_decoder_if.sv | 32 +++
 rtl/gray_decoder.sv | 121 ++++++++++++
 tb/tb_gray_decoder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/gray_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : gray_decoder_if
//  Description : Sample/result bundle between a Gray-code source and the
//                gray_decoder block. The source drives valid/gray/clr; the
//                decoder returns the binary value, pulses and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gray_decoder_if;
    logic       valid;
    logic [2:0] gray;
    logic       clr;
    logic [2:0] bin;
    logic       bin_valid;
    logic       wrap;
    logic [3:0] wrap_count;
    logic       error;
    logic       locked;

    // Sample source side
    modport master (
        output valid, gray, clr,
        input  bin, bin_valid, wrap, wrap_count, error, locked
    );

    // Decoder side
    modport slave (
        input  valid, gray, clr,
        output bin, bin_valid, wrap, wrap_count, error, locked
    );
endinterface
`default_nettype wire

// File: rtl/gray_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : gray_decoder
//  Description : 3-bit reflected Gray to binary decoder with step checking.
//                Locks on the first sample, then accepts only "hold" or
//                "+1 mod 8" steps; anything else latches a sticky error and
//                parks in FAULT until clr. Counts 7->0 wraps (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_decoder (
    input  wire          clk,
    input  wire          rst_n,
    gray_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    localparam logic [3:0] C_WRAP_MAX = 4'hF;
    localparam logic [2:0] C_BIN_MAX  = 3'd7;

    state_t     state_q, state_d;
    logic [2:0] bin_q, bin_d;
    logic       bin_valid_q, bin_valid_d;
    logic       wrap_q, wrap_d;
    logic [3:0] wrap_count_q, wrap_count_d;
    logic       error_q, error_d;

    logic [2:0] w_bin_new;
    logic [2:0] w_bin_inc;

    // Gray-to-binary conversion: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        w_bin_new[2] = bus.gray[2];
        w_bin_new[1] = bus.gray[2] ^ bus.gray[1];
        w_bin_new[0] = bus.gray[2] ^ bus.gray[1] ^ bus.gray[0];
        w_bin_inc    = bin_q + 3'd1;
    end

    // Next-state and output decision; clr outranks any sample in the same cycle
    always_comb begin
        state_d      = state_q;
        bin_d        = bin_q;
        bin_valid_d  = 1'b0;
        wrap_d       = 1'b0;
        wrap_count_d = wrap_count_q;
        error_d      = error_q;

        if (bus.clr) begin
            state_d      = ST_UNLOCKED;
            error_d      = 1'b0;
            wrap_count_d = 4'd0;
        end else if (bus.valid) begin
            case (state_q)
                ST_UNLOCKED: begin
                    // First sample is taken as the reference without a step check
                    bin_d       = w_bin_new;
                    bin_valid_d = 1'b1;
                    state_d     = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (w_bin_new == bin_q) begin
                        bin_valid_d = 1'b1;
                    end else if (w_bin_new == w_bin_inc) begin
                        bin_d       = w_bin_new;
                        bin_valid_d = 1'b1;
                        if (bin_q == C_BIN_MAX) begin
                            wrap_d = 1'b1;
                            if (wrap_count_q != C_WRAP_MAX) begin
                                wrap_count_d = wrap_count_q + 4'd1;
                            end
                        end
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    // Samples are ignored until clr
                end
                default: begin
                    state_d = ST_UNLOCKED;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_UNLOCKED;
            bin_q        <= 3'd0;
            bin_valid_q  <= 1'b0;
            wrap_q       <= 1'b0;
            wrap_count_q <= 4'd0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            bin_valid_q  <= bin_valid_d;
            wrap_q       <= wrap_d;
            wrap_count_q <= wrap_count_d;
            error_q      <= error_d;
        end
    end

    // Output mapping; locked is a pure decode of the state register
    always_comb begin
        bus.bin        = bin_q;
        bus.bin_valid  = bin_valid_q;
        bus.wrap       = wrap_q;
        bus.wrap_count = wrap_count_q;
        bus.error      = error_q;
        bus.locked     = (state_q == ST_LOCKED);
    end

endmodule
`default_nettype wire

// File: tb/tb_gray_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_decoder
//  Description : Self-checking bench for gray_decoder. A reference model
//                tracks the decoded position as an index into the Gray
//                sequence table and judges steps by modular distance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    gray_decoder_if bus ();

    gray_decoder u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Position in this table is the binary value of the Gray code
    int seq [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_bin;
    bit m_bv;
    bit m_wrap;
    int m_wc;
    bit m_err;
    bit m_have;
    bit m_fault;

    function automatic int gray_pos(input logic [2:0] g);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if (seq[i] == int'(g)) p = i;
        end
        return p;
    endfunction

    task automatic model_reset();
        m_bin = 0; m_bv = 0; m_wrap = 0; m_wc = 0;
        m_err = 0; m_have = 0; m_fault = 0;
    endtask

    task automatic model_edge();
        int b;
        int d;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_bv = 0;
            m_wrap = 0;
            if (bus.clr) begin
                m_have = 0; m_fault = 0; m_err = 0; m_wc = 0;
            end else if (bus.valid && !m_fault) begin
                b = gray_pos(bus.gray);
                if (!m_have) begin
                    m_bin = b; m_bv = 1; m_have = 1;
                end else begin
                    d = (b - m_bin + 8) % 8;
                    if (d == 0) begin
                        m_bv = 1;
                    end else if (d == 1) begin
                        if (m_bin == 7) begin
                            m_wrap = 1;
                            m_wc = (m_wc < 15) ? m_wc + 1 : 15;
                        end
                        m_bin = b;
                        m_bv = 1;
                    end else begin
                        m_err = 1;
                        m_fault = 1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".bin"},        {5'd0, bus.bin},        8'(m_bin));
        chk({tag, ".bin_valid"},  {7'd0, bus.bin_valid},  {7'd0, m_bv});
        chk({tag, ".wrap"},       {7'd0, bus.wrap},       {7'd0, m_wrap});
        chk({tag, ".wrap_count"}, {4'd0, bus.wrap_count}, 8'(m_wc));
        chk({tag, ".error"},      {7'd0, bus.error},      {7'd0, m_err});
        chk({tag, ".locked"},     {7'd0, bus.locked},     {7'd0, (m_have && !m_fault)});
    endtask

    // One clock cycle: drive, let the edge happen, update the model, check
    task automatic apply(input string tag, input bit v, input int g, input bit c);
        bus.valid = v;
        bus.gray  = 3'(g);
        bus.clr   = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    int r;
    int g;
    bit v;
    bit c;

    initial begin
        bus.valid = 1'b0;
        bus.gray  = 3'd0;
        bus.clr   = 1'b0;
        model_reset();

        // Reset held across edges, even with a valid sample present
        apply("rst_hold", 1'b1, 3, 1'b0);
        apply("rst_hold2", 1'b0, 0, 1'b0);
        #3 rst_n = 1'b1;

        // Reset release then three consecutive legal samples: bin 2,3,4
        apply("seq_011", 1'b1, 3'b011, 1'b0);
        apply("seq_010", 1'b1, 3'b010, 1'b0);
        apply("seq_110", 1'b1, 3'b110, 1'b0);

        // Continue up to 7, then wrap to 0
        apply("seq_111", 1'b1, 3'b111, 1'b0);
        apply("seq_101", 1'b1, 3'b101, 1'b0);
        apply("seq_100", 1'b1, 3'b100, 1'b0);
        apply("wrap_000", 1'b1, 3'b000, 1'b0);
        apply("wrap_gap", 1'b0, 3'b000, 1'b0);

        // Sixteen more full revolutions: wrap count saturates at 15
        for (int i = 0; i < 128; i++) begin
            apply("wrap_sat", 1'b1, seq[(i + 1) % 8], 1'b0);
        end

        // Skip from 2 to 4 faults; subsequent samples are ignored
        apply("clr_a", 1'b0, 0, 1'b1);
        apply("lock_2", 1'b1, 3'b011, 1'b0);
        apply("skip_4", 1'b1, 3'b110, 1'b0);
        apply("fault_ign1", 1'b1, 3'b010, 1'b0);
        apply("fault_ign2", 1'b1, 3'b011, 1'b0);

        // Clr with a simultaneous sample discards it; next sample locks
        apply("clr_discard", 1'b1, 3'b001, 1'b1);
        apply("relock_1", 1'b1, 3'b001, 1'b0);

        // Walk to 5, hold, then idle gaps
        apply("to_2", 1'b1, 3'b011, 1'b0);
        apply("to_3", 1'b1, 3'b010, 1'b0);
        apply("to_4", 1'b1, 3'b110, 1'b0);
        apply("to_5", 1'b1, 3'b111, 1'b0);
        apply("hold_5", 1'b1, 3'b111, 1'b0);
        for (int i = 0; i < 3; i++) apply("idle_gap", 1'b0, 3'b000, 1'b0);

        // Backward step is illegal too
        apply("back_4", 1'b1, 3'b110, 1'b0);

        // Build wrap count 3, then assert reset between edges
        apply("clr_b", 1'b0, 0, 1'b1);
        for (int i = 0; i < 25; i++) apply("wc3", 1'b1, seq[i % 8], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        apply("rst_valid_ignored", 1'b1, 3'b011, 1'b0);
        #3 rst_n = 1'b1;
        apply("post_rst_first", 1'b1, 3'b101, 1'b0);
        apply("post_rst_next", 1'b1, 3'b100, 1'b0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      g = seq[(m_bin + 1) % 8];
            else if (r < 65) g = seq[m_bin];
            else             g = $urandom_range(0, 7);
            v = ($urandom_range(0, 3) != 0);
            c = m_fault ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 39) == 0);
            apply("rand", v, g, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
